y86_seq_controller: RTL and testbench

Y86_SEQ_CONTROLLER -- requirements
Module: y86_seq_controller

---
 rtl/y86_seq_controller.sv | 140 ++++++++++++++
 tb/tb_y86_seq_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequential Y86-64 controller: FETCH..PC_UPDATE stage strobes, memory handshake with timeout.
// Optional performance counters are compiled in when Y86_PERF_CNT_EN is defined.
module y86_seq_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ack,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pcu_en,
  output logic        cc_we,
  output logic        mem_req,
  output logic        reg_we,
  output logic        pc_we,
  output logic [2:0]  stat,
  output logic        retired,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPDATE, HALTED, FAULT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q;
  logic [7:0]  wait_q, wait_d;
  logic [10:0] ctl_q, ctl_d;
  logic        is_mem, writes_reg;

  assign is_mem     = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign writes_reg = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH: begin
        if (imem_error)        begin state_d = FAULT;  stat_d = STAT_ADR; end
        else if (!instr_valid) begin state_d = FAULT;  stat_d = STAT_INS; end
        else if (icode == 4'h0) begin state_d = HALTED; stat_d = STAT_HLT; end
        else                   state_d = DECODE;
      end
      DECODE:    state_d = EXECUTE;
      EXECUTE: begin
        state_d = MEMORY;
        wait_d  = '0;
      end
      MEMORY: begin
        // An ack arriving in the last allowed cycle takes priority over the timeout.
        if (!is_mem) state_d = WRITEBACK;
        else if (mem_ack) begin
          if (dmem_error) begin state_d = FAULT; stat_d = STAT_ADR; end
          else            state_d = WRITEBACK;
        end
        else if (wait_q == WAIT_LAST) begin state_d = FAULT; stat_d = STAT_ADR; end
        else wait_d = wait_q + 8'd1;
      end
      WRITEBACK: state_d = PC_UPDATE;
      PC_UPDATE: state_d = FETCH;
      HALTED, FAULT: state_d = state_q;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      FETCH:     ctl_d[10] = 1'b1;
      DECODE:    ctl_d[9]  = 1'b1;
      EXECUTE:   begin ctl_d[8] = 1'b1; ctl_d[4] = (icode_q == 4'h6); end
      MEMORY:    begin ctl_d[7] = 1'b1; ctl_d[3] = is_mem; end
      WRITEBACK: begin ctl_d[6] = 1'b1; ctl_d[2] = writes_reg; end
      PC_UPDATE: begin ctl_d[5] = 1'b1; ctl_d[1] = 1'b1; ctl_d[0] = 1'b1; end
      default:   ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
      wait_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
      ctl_q   <= ctl_d;
      if (state_q == FETCH) icode_q <= icode;
    end
  end

  assign {fetch_en, decode_en, exec_en, mem_en, wb_en, pcu_en,
          cc_we, mem_req, reg_we, pc_we, retired} = ctl_q;
  assign stat = stat_q;

`ifdef Y86_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;
  logic        active;

  assign active = state_q inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPDATE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (active && cycle_q != 32'hFFFF_FFFF)  cycle_q <= cycle_q + 32'd1;
      if (retired && instr_q != 32'hFFFF_FFFF) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: per-cycle expected outputs are queued with the stimulus
// and compared on the falling edge; counters are checked against the bench's own cycle tally.
module tb_y86_seq_controller;
  localparam int TO = 4;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [10:0] C_F = 11'b100000_00000, C_D = 11'b010000_00000,
                          C_E = 11'b001000_00000, C_M = 11'b000100_00000,
                          C_W = 11'b000010_00000, C_P = 11'b000001_00000,
                          CC  = 11'b000000_10000, MREQ = 11'b000000_01000,
                          RWE = 11'b000000_00100, PCWE = 11'b000000_00010,
                          RET = 11'b000000_00001;

  typedef struct packed {
    logic       start;
    logic [3:0] icode;
    logic       valid;
    logic       imerr;
    logic       ack;
    logic       derr;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n, start, instr_valid, imem_error, mem_ack, dmem_error;
  logic [3:0] icode;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pcu_en;
  logic cc_we, mem_req, reg_we, pc_we, retired;
  logic [2:0] stat;
  logic [31:0] cycle_cnt, instr_cnt;

  logic [13:0] exp_q[$];
  stim_t       stim_q[$];
  int n_vec = 0, n_err = 0;
  int m_cyc = 0, m_ins = 0;

  y86_seq_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
    .wb_en(wb_en), .pcu_en(pcu_en), .cc_we(cc_we), .mem_req(mem_req), .reg_we(reg_we),
    .pc_we(pc_we), .stat(stat), .retired(retired), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en, pcu_en,
            cc_we, mem_req, reg_we, pc_we, retired, stat};
  endfunction

  function automatic stim_t mk(logic s, logic [3:0] ic, logic v, logic ie, logic a, logic de);
    stim_t t;
    t.start = s; t.icode = ic; t.valid = v; t.imerr = ie; t.ack = a; t.derr = de;
    return t;
  endfunction

  task automatic apply(input stim_t s);
    start = s.start; icode = s.icode; instr_valid = s.valid;
    imem_error = s.imerr; mem_ack = s.ack; dmem_error = s.derr;
  endtask

  task automatic push(input logic [10:0] ctl, input logic [2:0] st, input stim_t s);
    exp_q.push_back({ctl, st});
    stim_q.push_back(s);
    if (ctl[10:5] != 6'b0) m_cyc++;
    if (ctl[0]) m_ins++;
  endtask

  // Terminal state: everything idle, stat held, start and handshakes ignored.
  task automatic push_term(input logic [2:0] st);
    for (int i = 0; i < 3; i++) push(11'b0, st, mk(1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0));
  endtask

  // waits = MEMORY cycles without ack before the ack cycle; ack_en=0 means ack never comes.
  task automatic push_instr(input logic [3:0] ic, input logic valid, input logic imerr,
                            input int waits, input logic ack_en, input logic derr);
    logic is_mem, wr;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    wr     = ic inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    push(C_F, AOK, mk(1'b0, ic, valid, imerr, 1'b0, 1'b0));
    if (imerr)      begin push_term(ADR); return; end
    if (!valid)     begin push_term(INS); return; end
    if (ic == 4'h0) begin push_term(HLT); return; end
    push(C_D, AOK, mk(1'b0, ~ic, 1'b0, 1'b1, 1'b0, 1'b0));
    push(C_E | ((ic == 4'h6) ? CC : 11'b0), AOK, mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0));
    if (is_mem && !ack_en) begin
      for (int w = 0; w < TO; w++) push(C_M | MREQ, AOK, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1));
      push_term(ADR);
      return;
    end
    if (is_mem) begin
      for (int w = 0; w <= waits; w++)
        push(C_M | MREQ, AOK, mk(1'b0, 4'h0, 1'b0, 1'b0, w == waits, (w == waits) ? derr : 1'b1));
      if (derr) begin push_term(ADR); return; end
    end else begin
      push(C_M, AOK, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    push(C_W | (wr ? RWE : 11'b0), AOK, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    push(C_P | PCWE | RET, AOK, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_start();
    push(11'b0, AOK, mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run(input string name);
    logic [13:0] e;
    stim_t s;
    int cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: outputs got %b required %b", name, cyc, obs(), e);
      end
      apply(s);
      cyc++;
    end
  endtask

  task automatic check_cnt(input string name);
    logic [31:0] ec, ei;
`ifdef Y86_PERF_CNT_EN
    ec = 32'(m_cyc); ei = 32'(m_ins);
`else
    ec = 32'd0; ei = 32'd0;
`endif
    n_vec++;
    if (cycle_cnt !== ec) begin
      n_err++;
      $display("FAIL %s cycle_cnt: got %0d required %0d", name, cycle_cnt, ec);
    end
    n_vec++;
    if (instr_cnt !== ei) begin
      n_err++;
      $display("FAIL %s instr_cnt: got %0d required %0d", name, instr_cnt, ei);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs() !== {11'b0, AOK}) begin
      n_err++;
      $display("FAIL reset outputs: got %b required %b", obs(), {11'b0, AOK});
    end
    m_cyc = 0; m_ins = 0;
    check_cnt("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    push(11'b0, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    push(11'b0, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    run("idle_hold");
  endtask

  task automatic test_program();
    do_reset();
    push_start();
    push_instr(4'h3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    push_instr(4'h6, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    push_instr(4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    run("irmov_op_halt");
    check_cnt("irmov_op_halt");
  endtask

  task automatic test_mem_wait();
    do_reset();
    push_start();
    push_instr(4'h5, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    push_instr(4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    run("mrmov_wait3");
    check_cnt("mrmov_wait3");
  endtask

  task automatic test_timeout();
    do_reset();
    push_start();
    push_instr(4'h4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run("rmmov_timeout");
    check_cnt("rmmov_timeout");
  endtask

  task automatic test_dmem_error();
    do_reset();
    push_start();
    push_instr(4'h8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    run("dmem_error");
  endtask

  task automatic test_bad_instr();
    do_reset();
    push_start();
    push_instr(4'h2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run("invalid_instr");
    check_cnt("invalid_instr");
    do_reset();
    push_start();
    push_instr(4'h2, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run("imem_error");
  endtask

  task automatic test_back_to_back();
    logic [3:0] ics[11];
    int         wts[11];
    ics = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    wts = '{0, 0, 0, 0, 2, 0, 0, 1, 0, 3, 1};
    do_reset();
    push_start();
    for (int i = 0; i < 11; i++) push_instr(ics[i], 1'b1, 1'b0, wts[i], 1'b1, 1'b0);
    push_instr(4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    run("back_to_back");
    check_cnt("back_to_back");
  endtask

  task automatic test_abort();
    do_reset();
    push_start();
    push(C_F, AOK, mk(1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0));
    push(C_D, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    push(C_E, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    push(C_M | MREQ, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    push(C_M | MREQ, AOK, mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    run("abort_pre");
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== {11'b0, AOK}) begin
      n_err++;
      $display("FAIL abort_async: got %b required %b", obs(), {11'b0, AOK});
    end
    m_cyc = 0; m_ins = 0;
    check_cnt("abort_async");
    @(negedge clk);
    rst_n = 1'b1;
    push_start();
    push_instr(4'h2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    push_instr(4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    run("abort_restart");
    check_cnt("abort_restart");
  endtask

  initial begin
    rst_n = 1'b0;
    apply(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    test_reset();
    test_program();
    test_mem_wait();
    test_timeout();
    test_dmem_error();
    test_bad_instr();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
